// File: rtl/switch_key_pkg.sv
// Shared definitions for the switch/key input port: register offsets,
// default parameters and the address decode helper.
package switch_key_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR       = 32'hFFFF_FFF4;
  localparam int          DEFAULT_DEBOUNCE_CYCLES = 50000;

  localparam logic [31:0] OFF_SW_LEVEL  = 32'd0;
  localparam logic [31:0] OFF_KEY_LEVEL = 32'd1;
  localparam logic [31:0] OFF_KEY_EDGE  = 32'd2;

  typedef enum logic [1:0] {
    SEL_SW_LEVEL  = 2'd0,
    SEL_KEY_LEVEL = 2'd1,
    SEL_KEY_EDGE  = 2'd2,
    SEL_NONE      = 2'd3
  } reg_sel_e;

  typedef struct packed {
    logic     hit;
    reg_sel_e sel;
  } decode_t;

  // Map a bus address onto one of the three registers (offset is taken
  // modulo 2^32 so a base near the top of the map still decodes).
  function automatic decode_t decode_addr(input logic [31:0] addr,
                                          input logic [31:0] base);
    logic [31:0] off;
    decode_t     res;
    off = addr - base;
    case (off)
      OFF_SW_LEVEL:  res = '{hit: 1'b1, sel: SEL_SW_LEVEL};
      OFF_KEY_LEVEL: res = '{hit: 1'b1, sel: SEL_KEY_LEVEL};
      OFF_KEY_EDGE:  res = '{hit: 1'b1, sel: SEL_KEY_EDGE};
      default:       res = '{hit: 1'b0, sel: SEL_NONE};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/switch_key_port_if.sv
// CPU data-bus view of the switch/key port: address, write strobe and data
// from the CPU; combinational read data and hit flag back.
interface switch_key_port_if;

  logic [31:0] A;
  logic        WE;
  logic [31:0] D;
  logic [31:0] RD;
  logic        HIT;

  modport master (
    output A, WE, D,
    input  RD, HIT
  );

  modport slave (
    input  A, WE, D,
    output RD, HIT
  );

endinterface

// File: rtl/switch_key_port_debounce.sv
// One input bit: two-flop synchronizer followed by a stable-count debouncer.
// The synchronizer and the debounced level both reset to RESET_LEVEL so a
// line sitting at its idle level through reset produces no change.
module debounce_bit
  import switch_key_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_r;
  logic [CW-1:0] cnt_r;
  logic          level_r;

  // Synchronize the raw line, count consecutive differing cycles, and accept
  // the new level once it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r  <= {2{RESET_LEVEL}};
      cnt_r   <= {CW{1'b0}};
      level_r <= RESET_LEVEL;
    end else begin
      sync_r <= {sync_r[0], raw};
      if (sync_r[1] == level_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        level_r <= sync_r[1];
        cnt_r   <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign level = level_r;

endmodule

// File: rtl/switch_key_port.sv
// Memory-mapped input port: debounced slide switches, debounced push-buttons
// (reported as 1 = pressed) and sticky write-1-to-clear press flags, read
// back combinationally in the same bus cycle.
module switch_key_port
  import switch_key_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int          N_SW            = 10,
  parameter int          N_KEY           = 4,
  parameter int          DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic              CLK,
  input  logic              RST_N,
  switch_key_port_if.slave  bus,
  input  logic [N_SW-1:0]   SW,
  input  logic [N_KEY-1:0]  KEY
);

  logic [N_SW-1:0]  sw_db_s;
  logic [N_KEY-1:0] key_raw_db_s;
  logic [N_KEY-1:0] key_db_s;
  logic [N_KEY-1:0] key_prev_r;
  logic [N_KEY-1:0] edge_r;
  logic [N_KEY-1:0] key_set_s;
  logic [N_KEY-1:0] key_clr_s;
  logic [31:0]      rd_s;
  decode_t          dec_s;
  logic             unused_d_s;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (1'b0)
    ) u_db (
      .clk   (CLK),
      .rst_n (RST_N),
      .raw   (SW[i]),
      .level (sw_db_s[i])
    );
  end

  // Keys are debounced on the raw active-low line (idle = 1) and inverted
  // afterwards, so a released button reads 0 straight out of reset.
  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (1'b1)
    ) u_db (
      .clk   (CLK),
      .rst_n (RST_N),
      .raw   (KEY[i]),
      .level (key_raw_db_s[i])
    );
  end

  assign key_db_s = ~key_raw_db_s;

  // Only the low N_KEY data bits act as clear mask; fold the rest away.
  assign unused_d_s = ^bus.D;

  // Decode the bus address to a register select.
  always_comb begin
    dec_s = decode_addr(bus.A, BASE_ADDR);
  end

  // Press detection and the write-1-to-clear mask for the flag register.
  always_comb begin
    key_set_s = key_db_s & ~key_prev_r;
    if (bus.WE && (dec_s.sel == SEL_KEY_EDGE)) begin
      key_clr_s = bus.D[N_KEY-1:0];
    end else begin
      key_clr_s = {N_KEY{1'b0}};
    end
  end

  // Track the previous debounced key level and update sticky press flags;
  // a press arriving with a clear of the same bit keeps the flag set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_prev_r <= {N_KEY{1'b0}};
      edge_r     <= {N_KEY{1'b0}};
    end else begin
      key_prev_r <= key_db_s;
      edge_r     <= (edge_r & ~key_clr_s) | key_set_s;
    end
  end

  // Combinational read mux; unmapped addresses return zero.
  always_comb begin
    rd_s = 32'd0;
    case (dec_s.sel)
      SEL_SW_LEVEL:  rd_s = 32'(sw_db_s);
      SEL_KEY_LEVEL: rd_s = 32'(key_db_s);
      SEL_KEY_EDGE:  rd_s = 32'(edge_r);
      default:       rd_s = 32'd0;
    endcase
  end

  assign bus.RD  = rd_s;
  assign bus.HIT = dec_s.hit;

endmodule

// File: tb/tb_switch_key_port.sv
// Directed bench for switch_key_port with a short debounce window.
module tb_switch_key_port;

  localparam int N_SW  = 10;
  localparam int N_KEY = 4;
  localparam int DBC   = 4;

  localparam logic [31:0] A_SW   = 32'hFFFF_FFF4;
  localparam logic [31:0] A_KLVL = 32'hFFFF_FFF5;
  localparam logic [31:0] A_KEDG = 32'hFFFF_FFF6;
  localparam logic [31:0] A_MISS = 32'hFFFF_FFF7;

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [31:0] d;
    logic [31:0] rd;
    logic        hit;
    logic        step;
    string       name;
  } vec_t;

  logic             CLK;
  logic             RST_N;
  logic [N_SW-1:0]  SW;
  logic [N_KEY-1:0] KEY;
  int               n_vec;
  int               n_bad;
  vec_t             t1[5];
  vec_t             t4[9];

  switch_key_port_if bus();

  switch_key_port #(
    .BASE_ADDR       (32'hFFFF_FFF4),
    .N_SW            (N_SW),
    .N_KEY           (N_KEY),
    .DEBOUNCE_CYCLES (DBC)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus),
    .SW    (SW),
    .KEY   (KEY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd_check(input string nm, input logic [31:0] a, input logic [31:0] exp);
    bus.A  = a;
    bus.WE = 1'b0;
    bus.D  = 32'd0;
    #1;
    check(nm, bus.RD, exp);
  endtask

  task automatic apply_vec(input vec_t v);
    bus.A  = v.a;
    bus.WE = v.we;
    bus.D  = v.d;
    #1;
    check({v.name, "_rd"}, bus.RD, v.rd);
    check({v.name, "_hit"}, {31'd0, bus.HIT}, {31'd0, v.hit});
    if (v.step) begin
      tick();
      bus.WE = 1'b0;
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    t1[0] = '{A_SW,          1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "rst_sw"};
    t1[1] = '{A_KLVL,        1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "rst_klvl"};
    t1[2] = '{A_KEDG,        1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "rst_kedg"};
    t1[3] = '{A_MISS,        1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "rst_miss_hi"};
    t1[4] = '{32'hFFFF_FFF3, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "rst_miss_lo"};

    t4[0] = '{A_KEDG, 1'b0, 32'd0,          32'h5,   1'b1, 1'b0, "edge_pre"};
    t4[1] = '{A_KEDG, 1'b1, 32'h4,          32'h5,   1'b1, 1'b1, "w1c_same"};
    t4[2] = '{A_KEDG, 1'b0, 32'd0,          32'h1,   1'b1, 1'b0, "w1c_after"};
    t4[3] = '{A_SW,   1'b1, 32'hFFFF_FFFF,  32'h2A5, 1'b1, 1'b1, "ro_write"};
    t4[4] = '{A_KEDG, 1'b0, 32'd0,          32'h1,   1'b1, 1'b0, "edge_kept"};
    t4[5] = '{A_SW,   1'b0, 32'd0,          32'h2A5, 1'b1, 1'b0, "sw_kept"};
    t4[6] = '{A_KLVL, 1'b0, 32'd0,          32'h5,   1'b1, 1'b0, "klvl"};
    t4[7] = '{A_MISS, 1'b1, 32'hFFFF_FFFF,  32'd0,   1'b0, 1'b1, "miss_write"};
    t4[8] = '{A_KEDG, 1'b0, 32'd0,          32'h1,   1'b1, 1'b0, "edge_final"};

    RST_N  = 1'b0;
    KEY    = 4'hF;
    SW     = 10'h000;
    bus.A  = 32'd0;
    bus.WE = 1'b0;
    bus.D  = 32'd0;
    #22;
    RST_N = 1'b1;
    tick();
    tick();

    // 1: reset state and decode
    for (int i = 0; i < 5; i++) apply_vec(t1[i]);

    // 2: switch latency
    SW = 10'h2A5;
    for (int e = 1; e <= 8; e++) begin
      tick();
      rd_check($sformatf("sw_lat_e%0d", e), A_SW, (e >= 6) ? 32'h2A5 : 32'd0);
    end

    // 3: KEY[2] glitch rejected, then a held press
    KEY = 4'hB;
    for (int e = 1; e <= 3; e++) begin
      tick();
      rd_check($sformatf("glitch_lo_e%0d", e), A_KLVL, 32'd0);
    end
    KEY = 4'hF;
    for (int e = 1; e <= 6; e++) begin
      tick();
      rd_check($sformatf("glitch_hi_lvl_e%0d", e), A_KLVL, 32'd0);
      rd_check($sformatf("glitch_hi_edg_e%0d", e), A_KEDG, 32'd0);
    end
    KEY = 4'hB;
    for (int e = 1; e <= 8; e++) begin
      tick();
      rd_check($sformatf("k2_lvl_e%0d", e), A_KLVL, (e >= 6) ? 32'h4 : 32'd0);
      rd_check($sformatf("k2_edg_e%0d", e), A_KEDG, (e >= 7) ? 32'h4 : 32'd0);
    end

    // 4: build KEY_EDGE = 5, then W1C and ignored writes
    KEY = 4'hA;
    for (int e = 1; e <= 8; e++) tick();
    for (int i = 0; i < 9; i++) apply_vec(t4[i]);

    // 5: press KEY[1] so its flag sets on the same edge as a clear of bit 1
    KEY = 4'h8;
    for (int e = 1; e <= 6; e++) begin
      tick();
      rd_check($sformatf("k1_edg_e%0d", e), A_KEDG, 32'h1);
    end
    rd_check("k1_lvl_e6", A_KLVL, 32'h7);
    bus.A  = A_KEDG;
    bus.WE = 1'b1;
    bus.D  = 32'h2;
    #1;
    check("setclr_same", bus.RD, 32'h1);
    tick();
    bus.WE = 1'b0;
    rd_check("set_wins", A_KEDG, 32'h3);
    bus.A  = A_KEDG;
    bus.WE = 1'b1;
    bus.D  = 32'h2;
    tick();
    bus.WE = 1'b0;
    rd_check("clr_bit1", A_KEDG, 32'h1);

    // 6: release all, then reset in the middle of a KEY[0] debounce
    KEY = 4'hF;
    for (int e = 1; e <= 8; e++) tick();
    rd_check("rel_lvl", A_KLVL, 32'd0);
    rd_check("rel_edg", A_KEDG, 32'h1);
    KEY = 4'hE;
    tick();
    tick();
    tick();
    RST_N = 1'b0;
    rd_check("arst_sw", A_SW, 32'd0);
    rd_check("arst_klvl", A_KLVL, 32'd0);
    rd_check("arst_kedg", A_KEDG, 32'd0);
    #1;
    RST_N = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      rd_check($sformatf("post_k0_lvl_e%0d", e), A_KLVL, (e >= 6) ? 32'h1 : 32'd0);
      rd_check($sformatf("post_k0_edg_e%0d", e), A_KEDG, (e >= 7) ? 32'h1 : 32'd0);
      rd_check($sformatf("post_sw_e%0d", e), A_SW, (e >= 6) ? 32'h2A5 : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
